// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - header+payload serial frame transmitter, optional parity via SERTX_PARITY_EN
module serial_frame_tx #(
    parameter int                    HEADER_W  = 6,
    parameter logic [HEADER_W-1:0]   HEADER    = 6'b110101,
    parameter int                    PAYLOAD_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkEn,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] dataIn,
    output logic                 serOut,
    output logic                 serOutValid,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_MAX = (HEADER_W > PAYLOAD_W) ? HEADER_W : PAYLOAD_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_W - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_W - 1);

`ifdef SERTX_PARITY_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    state_t               state;
    logic [PAYLOAD_W-1:0] shreg;
    logic [CNT_W-1:0]     bitCnt;
    logic [PAYLOAD_W-1:0] sh_next;
    logic                 hdr_nb;
`ifdef SERTX_PARITY_EN
    logic                 parAcc;
`endif

    assign sh_next = shreg << 1;

    // Header bit that goes on the line after the current one (index HEADER_W-2-bitCnt)
    always_comb begin
        hdr_nb = 1'b0;
        for (int i = 0; i < HEADER_W - 1; i++) begin
            if (bitCnt == CNT_W'(HEADER_W - 2 - i)) begin
                hdr_nb = HEADER[i];
            end
        end
    end

    // Frame sequencer; line outputs are computed for the next state so they come straight from flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bitCnt      <= '0;
            serOut      <= 1'b0;
            serOutValid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SERTX_PARITY_EN
            parAcc      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg       <= dataIn;
                        bitCnt      <= '0;
                        state       <= HDR;
                        busy        <= 1'b1;
                        serOut      <= HEADER[HEADER_W-1];
                        serOutValid <= 1'b0;
`ifdef SERTX_PARITY_EN
                        parAcc      <= 1'b0;
`endif
                    end
                end
                HDR: begin
                    if (clkEn) begin
                        if (bitCnt == HDR_LAST) begin
                            state       <= PAY;
                            bitCnt      <= '0;
                            serOut      <= shreg[PAYLOAD_W-1];
                            serOutValid <= 1'b1;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                            serOut <= hdr_nb;
                        end
                    end
                end
                PAY: begin
                    if (clkEn) begin
                        shreg <= sh_next;
`ifdef SERTX_PARITY_EN
                        parAcc <= parAcc ^ shreg[PAYLOAD_W-1];
`endif
                        if (bitCnt == PAY_LAST) begin
                            bitCnt <= '0;
`ifdef SERTX_PARITY_EN
                            state  <= PAR;
                            serOut <= parAcc ^ shreg[PAYLOAD_W-1];
`else
                            state       <= IDLE;
                            serOut      <= 1'b0;
                            serOutValid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
`endif
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                            serOut <= sh_next[PAYLOAD_W-1];
                        end
                    end
                end
`ifdef SERTX_PARITY_EN
                PAR: begin
                    if (clkEn) begin
                        state       <= IDLE;
                        serOut      <= 1'b0;
                        serOutValid <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: the sending end of the lab's strobed serial link. On a start request it latches a parallel payload, then drives a fixed 6-bit header `110101` followed by the payload MSB-first onto `serOut`, advancing one bit per `clkEn` strobe. It sits upstream of the sequence-detecting receiver, and its frames are accepted unmodified by that receiver. `clkEn` comes from the pushbutton one-pulser on the board, or from a divider in simulation.

## Interface
- `HEADER`, default 6'b110101: header pattern, sent bit 5 first.
- `HEADER_W`, default 6: header length in bits.
- `PAYLOAD_W`, default 10: payload length in bits; must be ≥ 1.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clkEn` in 1: bit strobe, one `clk` wide; each high cycle advances one bit.
- `start` in 1: frame request; sampled only in IDLE.
- `dataIn` in `PAYLOAD_W`: payload; captured on the accepted `start` edge.
- `serOut` out 1: serial line; 0 when idle.
- `serOutValid` out 1: high while payload (and parity) bits are on `serOut`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a frame completes.

## Operation
- State machine with states IDLE, HDR, PAY, PAR; PAR exists only with the parity macro.
- Registers:
  - `shreg[PAYLOAD_W-1:0]`
  - bit counter `bitCnt`, sized for max(`HEADER_W`, `PAYLOAD_W`)
  - `parAcc`, present only with the parity macro
- IDLE:
  - `serOut`=0, `busy`=0.
  - `start`=1 → `shreg`←`dataIn`, `bitCnt`←0, next state HDR.
- HDR:
  - `serOut`=`HEADER[HEADER_W-1-bitCnt]`.
  - On `clkEn`: if `bitCnt`=`HEADER_W`-1, go to PAY with `bitCnt`←0; else `bitCnt`+1.
- PAY:
  - `serOut`=`shreg[PAYLOAD_W-1]`, `serOutValid`=1.
  - On `clkEn`: `shreg`←`shreg`<<1, and `parAcc` XORs in the outgoing bit.
  - If `bitCnt`=`PAYLOAD_W`-1: go to IDLE and pulse `done`, or go to PAR when parity is enabled. Otherwise `bitCnt`+1.
- PAR:
  - `serOut`=`parAcc`, `serOutValid`=1.
  - On `clkEn`: go to IDLE and pulse `done`.
- `serOut` and `serOutValid` are registered outputs (state-decoded from flops), so the line never glitches.
- `start` outside IDLE is ignored; there is no queueing.
- `dataIn` changes after capture do not affect the frame in flight.
- `clkEn` while in IDLE has no effect.

## Timing
- Reset values: state IDLE, `serOut`=0, `serOutValid`=0, `busy`=0, `done`=0, `shreg`=0, `bitCnt`=0, `parAcc`=0.
- Reset asserted mid-frame aborts immediately and asynchronously: `serOut` drops to 0 with no partial completion and no `done`.
- `start` accepted at edge k:
  - From edge k: `busy`=1 and `serOut`=`HEADER[5]`.
  - A `clkEn` in the same cycle as the accepted `start` is ignored, so the first bit always lasts a full strobe period.
- Each bit is held from the edge following one `clkEn` until the edge following the next `clkEn`.
- Frame length in strobes: `HEADER_W`+`PAYLOAD_W` (16 at defaults), plus 1 with parity.
- `done` is high for exactly the one cycle after the edge that consumes the last strobe; `busy` falls on that same edge.
- A new `start` is accepted at the earliest on the cycle `done` is high (state is IDLE). Back-to-back frames are therefore possible with no idle strobe between them.
- `bitCnt` never wraps; the terminal compare occurs before increment.

## Configuration
- `SERTX_PARITY_EN` defined:
  - PAR state present; an even-parity bit (XOR of payload bits) follows the payload, with `serOutValid`=1.
  - Frame is 17 strobes at defaults.
- Not defined:
  - PAR state and `parAcc` are absent; frame ends after the last payload bit.
  - Default build; matches the current receiver.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release `rst`, wait 5 cycles with no `start` → `serOut` stays 0.
- Basic frame: `dataIn`=10'b1011001110, `start` pulse, then `clkEn` every 4 cycles → `serOut` sequence 110101 then 1011001110. `serOutValid` is high for exactly the last 10 bits, and `done` pulses once after the 16th strobe.
- Ignore and capture: `start` re-asserted and `dataIn` changed to 10'h3FF mid-header → frame unchanged and only one `done` pulse.
- Same-cycle `start`+`clkEn`: → `serOut`=1 persists until the following strobe, and header bit count stays 6.
- Abort: `rst`=0 during payload bit 4 → immediate `serOut`=0 and `busy`=0 with no `done`. A subsequent `start` with `dataIn`=10'h155 sends a full correct frame.
- `SERTX_PARITY_EN` build: `dataIn`=10'b1011001110 (six ones) → 17th bit 0. `dataIn`=10'b1000000000 → 17th bit 1, and `done` follows the 17th strobe.
